// File: rtl/llpm_flow_pkg.sv
// Shared flow-control helpers for the llpm fork/join/FIFO blocks.
// A transfer on a valid/bp channel happens when valid is high and bp is low.
package llpm_flow_pkg;

  function automatic logic xfer(input logic valid, input logic bp);
    return valid & ~bp;
  endfunction

endpackage

// File: rtl/join_slot.sv
// One-entry holding register for a single join input channel.
// Captures d on load; clear empties it. A load in the same cycle as a clear wins.
module join_slot #(
  parameter int Width = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             clear,
  input  logic [Width-1:0] d,
  output logic [Width-1:0] q,
  output logic             held
);

  logic [Width-1:0] data_q, data_d;
  logic             held_q, held_d;

  always_comb begin
    data_d = data_q;
    held_d = held_q;
    if (clear) held_d = 1'b0;
    // NOTE: load is applied after clear so a token arriving as the slot drains is kept.
    if (load) begin
      data_d = d;
      held_d = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments only; the data register is
  // reset too so dout reads zero after reset rather than stale contents.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= '0;
      held_q <= 1'b0;
    end else begin
      data_q <= data_d;
      held_q <= held_d;
    end
  end

  assign q    = data_q;
  assign held = held_q;

endmodule

// File: rtl/buffered_join.sv
// Registered N-way join: one holding slot per channel, all slots fire together into an output register.
// Define BUFFERED_JOIN_REFILL_EN to let a slot accept a new token in the cycle it drains.
module buffered_join
  import llpm_flow_pkg::*;
#(
  parameter int Width     = 8,
  parameter int NumInputs = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NumInputs*Width-1:0] din,
  input  logic [NumInputs-1:0]       din_valid,
  output logic [NumInputs-1:0]       din_bp,
  output logic [NumInputs*Width-1:0] dout,
  output logic                       dout_valid,
  input  logic                       dout_bp
);

  logic [NumInputs-1:0]       held;
  logic [NumInputs-1:0]       accept;
  logic [NumInputs*Width-1:0] slot_data;
  logic                       fire;

  logic                       out_valid_q, out_valid_d;
  logic [NumInputs*Width-1:0] out_data_q,  out_data_d;

  // Fire once every slot is full and the output register is empty or draining now.
  assign fire = (&held) & (~out_valid_q | ~dout_bp);

`ifdef BUFFERED_JOIN_REFILL_EN
  assign din_bp = held & ~{NumInputs{fire}};
`else
  assign din_bp = held;
`endif

  for (genvar i = 0; i < NumInputs; i++) begin : g_slot
    assign accept[i] = xfer(din_valid[i], din_bp[i]);

    join_slot #(
      .Width (Width)
    ) u_slot (
      .clk   (clk),
      .reset (reset),
      .load  (accept[i]),
      .clear (fire),
      .d     (din[i*Width +: Width]),
      .q     (slot_data[i*Width +: Width]),
      .held  (held[i])
    );
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (fire) begin
      out_valid_d = 1'b1;
      out_data_d  = slot_data;
    end else if (out_valid_q && !dout_bp) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign dout_valid = out_valid_q;
  assign dout       = out_data_q;

  a_dout_stable : assert property (@(posedge clk) disable iff (reset)
    (out_valid_q && dout_bp) |=> $stable(out_data_q));

  a_held_blocks : assert property (@(posedge clk) disable iff (reset)
    ((held & ~{NumInputs{fire}} & ~din_bp) == '0));

endmodule
